pwm_capture: RTL

Multi-channel PWM input capture peripheral on the memory-mapped peripheral bus. It measures the period and high time of external PWM-like signals in system clock cycles and latches them into readable registers. It complements the PWM generator: it is the receive side of the same pulse-width signalling. It can raise a level interrupt when a new measurement is available.

---
 rtl/pwm_capture.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: multi-channel PWM input capture on the peripheral bus.
// Each channel measures period and high time of its input in clk cycles
// and latches them into readable registers; a level interrupt is raised
// while any channel has a fresh capture with its interrupt enabled.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   mem_addr   bus address; [31:8] block decode, [7:4] channel, [3:0] register
//   mem_wdata  write data
//   mem_we     single-cycle write strobe
//   mem_re     read strobe
//   mem_rdata  combinational read data, 0 when not selected or not reading
//   pwm_in     asynchronous PWM inputs, one per channel
//   irq        registered OR over channels of (VALID & IE)
//
// Register map per channel (offset within the channel's 16-byte window):
//   0x0 CTRL   RW    bit0 EN, bit1 IE
//   0x4 STATUS RW1C  bit0 VALID, bit1 OVF, bit2 OVR
//   0x8 PERIOD RO    last captured period
//   0xC HIGH   RO    last captured high time
module pwm_capture #(
  parameter logic [31:0] CAP_BASE_ADDR = 32'h4000_4000,
  parameter int          CAP_NUM       = 2,
  parameter int          COUNTER_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  input  logic               mem_we,
  input  logic               mem_re,
  output logic [31:0]        mem_rdata,
  input  logic [CAP_NUM-1:0] pwm_in,
  output logic               irq
);

  localparam logic [4:0]               NUM_CH = 5'(CAP_NUM);
  localparam logic [COUNTER_WIDTH-1:0] ONE    = COUNTER_WIDTH'(1);

  logic [3:0] ch_sel;
  logic [3:0] reg_sel;
  logic       ch_ok;
  logic       wr_ctrl_any;
  logic       wr_stat_any;

  assign ch_sel      = mem_addr[7:4];
  assign reg_sel     = mem_addr[3:0];
  assign ch_ok       = (mem_addr[31:8] == CAP_BASE_ADDR[31:8]) && ({1'b0, ch_sel} < NUM_CH);
  assign wr_ctrl_any = mem_we && ch_ok && (reg_sel == 4'h0);
  assign wr_stat_any = mem_we && ch_ok && (reg_sel == 4'h4);

  logic unused_wdata;
  assign unused_wdata = ^mem_wdata[31:3];

  logic [CAP_NUM-1:0]       en_v;
  logic [CAP_NUM-1:0]       ie_v;
  logic [CAP_NUM-1:0]       valid_v;
  logic [CAP_NUM-1:0]       ovf_v;
  logic [CAP_NUM-1:0]       ovr_v;
  logic [COUNTER_WIDTH-1:0] period_v [CAP_NUM];
  logic [COUNTER_WIDTH-1:0] high_v   [CAP_NUM];

  for (genvar g = 0; g < CAP_NUM; g++) begin : g_ch
    logic                     s1, s2, p;
    logic                     rise, fall;
    logic                     en_q, ie_q, valid_q, ovf_q, ovr_q;
    logic                     armed;
    logic [COUNTER_WIDTH-1:0] cnt, hi_lat, period_q, high_q;
    logic                     hit, wr_ctrl;
    logic [2:0]               clr;
    logic                     capture, sat;

    assign hit     = (ch_sel == 4'(g));
    assign wr_ctrl = wr_ctrl_any && hit;
    assign clr     = (wr_stat_any && hit) ? mem_wdata[2:0] : 3'b000;

    assign rise    = s2 & ~p;
    assign fall    = ~s2 & p;
    // A rise takes priority over saturation, so a rise seen while cnt is
    // all-ones still captures instead of flagging overflow.
    assign capture = en_q & rise & armed;
    assign sat     = en_q & ~rise & armed & (cnt == '1);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1       <= 1'b0;
        s2       <= 1'b0;
        p        <= 1'b0;
        en_q     <= 1'b0;
        ie_q     <= 1'b0;
        valid_q  <= 1'b0;
        ovf_q    <= 1'b0;
        ovr_q    <= 1'b0;
        armed    <= 1'b0;
        cnt      <= '0;
        hi_lat   <= '0;
        period_q <= '0;
        high_q   <= '0;
      end else begin
        s1 <= pwm_in[g];
        s2 <= s1;
        p  <= s2;

        if (wr_ctrl) begin
          en_q <= mem_wdata[0];
          ie_q <= mem_wdata[1];
        end

        // hardware set wins over a same-cycle write-1-clear
        valid_q <= (valid_q & ~clr[0]) | capture;
        ovf_q   <= (ovf_q   & ~clr[1]) | sat;
        ovr_q   <= (ovr_q   & ~clr[2]) | (capture & valid_q);

        if (capture) begin
          period_q <= cnt + ONE;
          high_q   <= hi_lat;
        end

        if (!en_q) begin
          cnt    <= '0;
          hi_lat <= '0;
          armed  <= 1'b0;
        end else if (rise) begin
          cnt   <= '0;
          armed <= 1'b1;
        end else if (armed) begin
          if (fall) hi_lat <= cnt + ONE;
          if (sat) begin
            cnt   <= '0;
            armed <= 1'b0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
      end
    end

    assign en_v[g]     = en_q;
    assign ie_v[g]     = ie_q;
    assign valid_v[g]  = valid_q;
    assign ovf_v[g]    = ovf_q;
    assign ovr_v[g]    = ovr_q;
    assign period_v[g] = period_q;
    assign high_v[g]   = high_q;
  end

  always_comb begin
    mem_rdata = '0;
    if (mem_re && ch_ok) begin
      for (int i = 0; i < CAP_NUM; i++) begin
        if (ch_sel == 4'(i)) begin
          case (reg_sel)
            4'h0:    mem_rdata = {30'd0, ie_v[i], en_v[i]};
            4'h4:    mem_rdata = {29'd0, ovr_v[i], ovf_v[i], valid_v[i]};
            4'h8:    mem_rdata = 32'(period_v[i]);
            4'hC:    mem_rdata = 32'(high_v[i]);
            default: mem_rdata = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= |(valid_v & ie_v);
  end

endmodule
